// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C FIFO transmit engine: command-word field
// positions, FSM state encoding and the default SCL quarter-period length.
package i2c_pkg;

    localparam int unsigned DATA_LEN_DEF = 15;
    localparam int unsigned QUARTER_DEF  = 250;

    localparam int unsigned START_BIT = 14;
    localparam int unsigned STOP_BIT  = 13;
    localparam int unsigned BYTE_MSB  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_START = 3'd3,
        ST_BIT   = 3'd4,
        ST_ACK   = 3'd5,
        ST_STOP  = 3'd6,
        ST_WAIT  = 3'd7
    } state_e;

    // States that step through SCL quarters and need the quarter tick.
    function automatic logic is_phase(input state_e s);
        return (s == ST_START) || (s == ST_BIT) || (s == ST_ACK) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timer: counts QUARTER cycles per quarter and steps a
// 2-bit quarter index; tick_o is high in the last cycle of each quarter.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int unsigned QUARTER = QUARTER_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       restart_i,
    output logic       tick_o,
    output logic [1:0] qidx_o
);

    localparam int unsigned CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qidx_q, qidx_d;
    logic          tick_q, tick_d;

    // Tick is registered by looking at the next count, so it lines up with cnt_q == QUARTER-1.
    always_comb begin
        cnt_d  = cnt_q;
        qidx_d = qidx_q;
        if (restart_i || !en_i) begin
            cnt_d  = '0;
            qidx_d = '0;
        end else if (cnt_q == CW'(QUARTER - 1)) begin
            cnt_d  = '0;
            qidx_d = qidx_q + 2'd1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == CW'(QUARTER - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            qidx_q <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            qidx_q <= qidx_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign qidx_o = qidx_q;

endmodule

// File: rtl/i2c_fifo_tx.sv
// I2C master transmit engine draining a command FIFO onto SCL/SDA.
// Define NACK_ABORT_EN to force STOP on NACK and flush words up to the next START.
module i2c_fifo_tx
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned QUARTER  = QUARTER_DEF
) (
    input  logic                CLK_IW,
    input  logic                RST_IW,
    input  logic                EMPTY_IW,
    input  logic [DATA_LEN-1:0] DATA_IN_I,
    output logic                READ_EN_OW,
    output logic                SCL_OW,
    output logic                SDA_OE_OW,
    input  logic                SDA_IW,
    output logic                BUSY_OW,
    output logic                NACK_OR
);

    state_e              state_q, state_d;
    logic [BYTE_MSB:0]   byte_q, byte_d;
    logic                stop_q, stop_d;
    logic                rep_q, rep_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                scl_q, scl_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                nack_q, nack_d;
    logic                rd_en_q, rd_en_d;

    logic                tick;
    logic [1:0]          qidx;
    logic                last_c;
    logic                abort_c;
    logic                unused_rsvd;

    assign unused_rsvd = ^DATA_IN_I[STOP_BIT-1:BYTE_MSB+1];

    i2c_quarter_tick #(
        .QUARTER(QUARTER)
    ) u_tick (
        .clk_i    (CLK_IW),
        .rst_n_i  (RST_IW),
        .en_i     (is_phase(state_q)),
        .restart_i(is_phase(state_d) && (state_d != state_q)),
        .tick_o   (tick),
        .qidx_o   (qidx)
    );

    assign last_c = tick && (qidx == 2'd3);

`ifdef NACK_ABORT_EN
    assign abort_c = nack_q;
`else
    assign abort_c = 1'b0;
`endif

    // State register plus registered outputs and datapath.
    always_ff @(posedge CLK_IW) begin
        if (!RST_IW) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            stop_q    <= 1'b0;
            rep_q     <= 1'b0;
            bit_cnt_q <= 3'd7;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            nack_q    <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            stop_q    <= stop_d;
            rep_q     <= rep_d;
            bit_cnt_q <= bit_cnt_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            nack_q    <= nack_d;
            rd_en_q   <= rd_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!EMPTY_IW) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                if (DATA_IN_I[START_BIT]) state_d = ST_START;
                else if (busy_q)          state_d = ST_BIT;
                else                      state_d = ST_IDLE;
            end
            ST_START: if (last_c) state_d = ST_BIT;
            ST_BIT:   if (last_c && (bit_cnt_q == 3'd0)) state_d = ST_ACK;
            ST_ACK: begin
                if (last_c) begin
                    if (stop_q || abort_c) state_d = ST_STOP;
                    else if (EMPTY_IW)     state_d = ST_WAIT;
                    else                   state_d = ST_FETCH;
                end
            end
            ST_STOP:  if (last_c) state_d = ST_IDLE;
            ST_WAIT:  if (!EMPTY_IW) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus levels per state/quarter; values hold across FETCH and LATCH.
    always_comb begin
        scl_d     = scl_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        nack_d    = nack_q;
        rd_en_d   = (state_d == ST_FETCH);
        byte_d    = byte_q;
        stop_d    = stop_q;
        rep_d     = rep_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            ST_LATCH: begin
                byte_d    = DATA_IN_I[BYTE_MSB:0];
                stop_d    = DATA_IN_I[STOP_BIT];
                rep_d     = busy_q;
                bit_cnt_d = 3'd7;
            end
            ST_START: begin
                busy_d = 1'b1;
                nack_d = 1'b0;
                if (rep_q) begin
                    if (qidx == 2'd0) begin
                        sda_oe_d = 1'b0;
                        scl_d    = 1'b0;
                    end
                    if (qidx == 2'd1) scl_d    = 1'b1;
                    if (qidx == 2'd2) sda_oe_d = 1'b1;
                    if (qidx == 2'd3) scl_d    = 1'b0;
                end else begin
                    if (qidx == 2'd0) begin
                        sda_oe_d = 1'b1;
                        scl_d    = 1'b1;
                    end
                    if (qidx == 2'd2) scl_d = 1'b0;
                end
            end
            ST_BIT: begin
                if (qidx == 2'd0) begin
                    scl_d    = 1'b0;
                    sda_oe_d = ~byte_q[bit_cnt_q];
                end
                if (qidx == 2'd1) scl_d = 1'b1;
                if (qidx == 2'd3) scl_d = 1'b0;
                if (last_c) bit_cnt_d = bit_cnt_q - 3'd1;
            end
            ST_ACK: begin
                if (qidx == 2'd0) begin
                    scl_d    = 1'b0;
                    sda_oe_d = 1'b0;
                end
                if (qidx == 2'd1) scl_d = 1'b1;
                if ((qidx == 2'd2) && tick && SDA_IW) nack_d = 1'b1;
                if (qidx == 2'd3) scl_d = 1'b0;
            end
            ST_STOP: begin
                if (qidx == 2'd0) begin
                    scl_d    = 1'b0;
                    sda_oe_d = 1'b1;
                end
                if (qidx == 2'd1) scl_d    = 1'b1;
                if (qidx == 2'd2) sda_oe_d = 1'b0;
            end
            ST_WAIT: begin
                scl_d    = 1'b0;
                sda_oe_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign READ_EN_OW = rd_en_q;
    assign SCL_OW     = scl_q;
    assign SDA_OE_OW  = sda_oe_q;
    assign BUSY_OW    = busy_q;
    assign NACK_OR    = nack_q;

endmodule

// File: tb/tb_i2c_fifo_tx.sv
// Directed bench for i2c_fifo_tx: FIFO model, open-drain bus with an ACKing
// slave, and a bus monitor that decodes START/STOP/bytes for comparison.
module tb_i2c_fifo_tx;

    localparam int unsigned QUARTER = 4;
    localparam int EV_S    = 256;
    localparam int EV_P    = 257;
    localparam int EV_NACK = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] fifo_dout = '0;
    logic        read_en, scl, sda_oe, busy, nack;
    logic        slv_low = 1'b0;
    logic        sda_line;
    logic        empty;
    logic [14:0] mem [64];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;

    int          ev[$];
    int          exp_ev[$];
    int          m_bits = 0;
    logic [7:0]  m_byte = '0;
    logic        m_ack = 1'b0;
    logic        p_scl = 1'b1;
    logic        p_sda = 1'b1;
    int          busy_cyc = 0;
    int          rd_cnt = 0;
    int          underflow = 0;
    int          t_rd = -1;
    int          t_oe = -1;
    int          cyc = 0;
    int          nack_byte = -1;
    int          errors = 0;
    int          checks = 0;

    assign sda_line = ~(sda_oe | slv_low);
    assign empty    = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    i2c_fifo_tx #(
        .DATA_LEN(15),
        .QUARTER (QUARTER)
    ) dut (
        .CLK_IW    (clk),
        .RST_IW    (rst_n),
        .EMPTY_IW  (empty),
        .DATA_IN_I (fifo_dout),
        .READ_EN_OW(read_en),
        .SCL_OW    (scl),
        .SDA_OE_OW (sda_oe),
        .SDA_IW    (sda_line),
        .BUSY_OW   (busy),
        .NACK_OR   (nack)
    );

    // FIFO read side: data valid the cycle after the pop strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read_en && (rd_ptr != wr_ptr)) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    // Bus monitor and slave: decode framing, ACK every byte except nack_byte.
    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda_line;
        if (!rst_n) begin
            m_bits  <= 0;
            slv_low <= 1'b0;
        end else begin
            if (s_scl && p_scl && p_sda && !s_sda) begin
                ev.push_back(EV_S);
                m_bits <= 0;
            end else if (s_scl && p_scl && !p_sda && s_sda) begin
                ev.push_back(EV_P);
                m_bits <= 0;
            end else if (s_scl && !p_scl) begin
                if (m_bits < 8) m_byte <= {m_byte[6:0], s_sda};
                else            m_ack  <= s_sda;
                m_bits <= m_bits + 1;
            end else if (!s_scl && p_scl) begin
                if (m_bits == 8) begin
                    slv_low <= (nack_byte != int'(m_byte));
                end else if (m_bits == 9) begin
                    slv_low <= 1'b0;
                    ev.push_back(m_ack ? (EV_NACK + int'(m_byte)) : int'(m_byte));
                    m_bits <= 0;
                end
            end
            if (busy) busy_cyc <= busy_cyc + 1;
            if (read_en) begin
                rd_cnt <= rd_cnt + 1;
                if (empty) underflow <= underflow + 1;
                if (t_rd < 0) t_rd <= cyc;
            end
            if (sda_oe && (t_rd >= 0) && (t_oe < 0)) t_oe <= cyc;
        end
        p_scl <= s_scl;
        p_sda <= s_sda;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic push(input logic [14:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic cmp_events(input string tag, input int base);
        check({tag, "_nev"}, ev.size() - base, exp_ev.size());
        for (int i = 0; i < exp_ev.size(); i++) begin
            if (base + i < ev.size()) check($sformatf("%s_ev%0d", tag, i), ev[base + i], exp_ev[i]);
            else                      check($sformatf("%s_ev%0d", tag, i), -1, exp_ev[i]);
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int quiet = 0;
        int n = 0;
        while ((quiet < 20) && (n < max)) begin
            @(negedge clk);
            n++;
            if (empty && !busy && scl && !sda_oe && !read_en) quiet++;
            else quiet = 0;
        end
        check({tag, "_idle"}, (quiet >= 20) ? 1 : 0, 1);
    endtask

    task automatic wait_ev(input string tag, input int n, input int max);
        int k = 0;
        while ((ev.size() < n) && (k < max)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_wait"}, (ev.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int base, b_busy, b_rd, k;

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_scl", int'(scl), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_rd_en", int'(read_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_nack", int'(nack), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single framed byte
        base = ev.size(); b_busy = busy_cyc; b_rd = rd_cnt;
        push(15'h60A5);
        run_idle("t1", 3000);
        exp_ev = '{EV_S, 'hA5, EV_P};
        cmp_events("t1", base);
        check("t1_nack", int'(nack), 0);
        check("t1_busy_cyc", busy_cyc - b_busy, 44 * QUARTER);
        check("t1_rd_pulses", rd_cnt - b_rd, 1);
        check("t1_oe_latency", t_oe - t_rd, 3);

        // Three bytes in one transfer
        base = ev.size(); b_rd = rd_cnt;
        push(15'h4078); push(15'h0001); push(15'h20FF);
        run_idle("t2", 4000);
        exp_ev = '{EV_S, 'h78, 'h01, 'hFF, EV_P};
        cmp_events("t2", base);
        check("t2_rd_pulses", rd_cnt - b_rd, 3);
        check("t2_nack", int'(nack), 0);

        // FIFO runs dry mid-transfer: bus held in WAIT
        base = ev.size(); b_rd = rd_cnt;
        push(15'h4010);
        wait_ev("t3", base + 2, 2000);
        repeat (250) @(negedge clk);
        check("t3_gap_scl", int'(scl), 0);
        check("t3_gap_busy", int'(busy), 1);
        check("t3_gap_sda_oe", int'(sda_oe), 0);
        repeat (250) @(negedge clk);
        check("t3_gap_rd_pulses", rd_cnt - b_rd, 1);
        push(15'h2022);
        run_idle("t3", 3000);
        exp_ev = '{EV_S, 'h10, 'h22, EV_P};
        cmp_events("t3", base);

        // Repeated START between bytes
        base = ev.size();
        push(15'h4090); push(15'h6091);
        run_idle("t4", 3000);
        exp_ev = '{EV_S, 'h90, EV_S, 'h91, EV_P};
        cmp_events("t4", base);

        // Slave NACKs the first byte
        base = ev.size(); b_rd = rd_cnt;
        nack_byte = 'hAA;
        push(15'h40AA); push(15'h0011); push(15'h6033);
        wait_ev("t5", base + 2, 2000);
        check("t5_nack_set", int'(nack), 1);
        run_idle("t5", 4000);
        nack_byte = -1;
`ifdef NACK_ABORT_EN
        exp_ev = '{EV_S, EV_NACK + 'hAA, EV_P, EV_S, 'h33, EV_P};
`else
        exp_ev = '{EV_S, EV_NACK + 'hAA, 'h11, EV_S, 'h33, EV_P};
`endif
        cmp_events("t5", base);
        check("t5_nack_cleared", int'(nack), 0);
        check("t5_rd_pulses", rd_cnt - b_rd, 3);

        // Word without START on an idle bus is dropped
        base = ev.size(); b_rd = rd_cnt; b_busy = busy_cyc;
        push(15'h0011);
        run_idle("t6", 500);
        exp_ev = '{};
        cmp_events("t6", base);
        check("t6_rd_pulses", rd_cnt - b_rd, 1);
        check("t6_busy_cyc", busy_cyc - b_busy, 0);

        // Reset in the middle of a byte
        push(15'h40C3); push(15'h6055);
        k = 0;
        while ((m_bits < 3) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        check("t7_reach_bit3", (m_bits >= 3) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_rst_scl", int'(scl), 1);
        check("t7_rst_sda_oe", int'(sda_oe), 0);
        check("t7_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        check("t7_rst_rd_en", int'(read_en), 0);
        base = ev.size(); b_rd = rd_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_first_pop", int'(read_en), 1);
        run_idle("t7", 3000);
        exp_ev = '{EV_S, 'h55, EV_P};
        cmp_events("t7", base);
        check("t7_rd_pulses", rd_cnt - b_rd, 1);

        check("no_underflow", underflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
